// File: rtl/line_buffer_taps_pkg.sv
// Shared helpers for the multi-row line buffer: pointer width, line-length clamp, tap slicing.
package line_buffer_pkg;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // A zero or oversize length means "full row memory".
    function automatic int clamp_len(input int len, input int max_len);
        return ((len == 0) || (len > max_len)) ? max_len : len;
    endfunction

    function automatic int tap_lsb(input int k, input int data_width);
        return k * data_width;
    endfunction

endpackage

// File: rtl/line_buffer_taps_if.sv
// Pixel-in / vertical-tap-out bundle for line_buffer_taps.
interface line_buffer_taps_if
    import line_buffer_pkg::*;
#(
    parameter int LINE_WIDTH = 640,
    parameter int DATA_WIDTH = 26,
    parameter int N_ROWS     = 2
);
    localparam int LEN_W = $clog2(LINE_WIDTH + 1);
    localparam int PTR_W = ptr_width(LINE_WIDTH);
    localparam int TAP_W = (N_ROWS + 1) * DATA_WIDTH;

    logic                  in_valid;
    logic                  in_sop;
    logic [DATA_WIDTH-1:0] data_in;
    logic [LEN_W-1:0]      line_len;
    logic                  out_valid;
    logic [TAP_W-1:0]      taps;
    logic                  window_valid;
    logic [PTR_W-1:0]      col_idx;

    modport master (
        output in_valid, in_sop, data_in, line_len,
        input  out_valid, taps, window_valid, col_idx
    );

    modport slave (
        input  in_valid, in_sop, data_in, line_len,
        output out_valid, taps, window_valid, col_idx
    );
endinterface

// File: rtl/line_buffer_taps_row_ram.sv
// One stored video line: LINE_WIDTH x DATA_WIDTH, combinational read, synchronous write.
module lb_row_ram
    import line_buffer_pkg::*;
#(
    parameter int LINE_WIDTH = 640,
    parameter int DATA_WIDTH = 26
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [ptr_width(LINE_WIDTH)-1:0] addr,
    input  logic [DATA_WIDTH-1:0]          wdata,
    output logic [DATA_WIDTH-1:0]          rdata
);
    logic [DATA_WIDTH-1:0] mem [LINE_WIDTH];

    // Read returns the pre-write word, so a row can forward its old pixel to the next row.
    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end
endmodule

// File: rtl/line_buffer_taps.sv
// Multi-row line buffer presenting an N_ROWS+1 pixel vertical column per accepted beat.
// Optional macro LINE_BUF_ZERO_PAD_EN zeroes taps of rows not yet filled in the current frame.
module line_buffer_taps
    import line_buffer_pkg::*;
#(
    parameter int LINE_WIDTH = 640,
    parameter int DATA_WIDTH = 26,
    parameter int N_ROWS     = 2
) (
    input  logic              clk,
    input  logic              rst,
    line_buffer_taps_if.slave bus
);
    localparam int LEN_W = $clog2(LINE_WIDTH + 1);
    localparam int PTR_W = ptr_width(LINE_WIDTH);
    localparam int RF_W  = $clog2(N_ROWS + 1);
    localparam int TAP_W = (N_ROWS + 1) * DATA_WIDTH;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [RF_W-1:0]  rows_q, rows_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [TAP_W-1:0] taps_q, taps_d;
    logic [PTR_W-1:0] col_q, col_d;
    logic             out_valid_q, out_valid_d;
    logic             window_valid_q, window_valid_d;

    logic             sop_beat;
    logic [PTR_W-1:0] wr_ptr;
    logic [LEN_W-1:0] len_eff;
    logic [RF_W-1:0]  rows_eff;
    logic             last_col;

    // col_rd[0] is the incoming pixel, col_rd[j] the pixel j lines above at this column.
    logic [DATA_WIDTH-1:0] col_rd [N_ROWS+1];

    assign col_rd[0] = bus.data_in;

    for (genvar j = 1; j <= N_ROWS; j++) begin : g_row
        lb_row_ram #(
            .LINE_WIDTH(LINE_WIDTH),
            .DATA_WIDTH(DATA_WIDTH)
        ) u_row (
            .clk  (clk),
            .we   (bus.in_valid),
            .addr (wr_ptr),
            .wdata(col_rd[j-1]),
            .rdata(col_rd[j])
        );
    end

    // A start-of-frame beat restarts column, fill count and line length on that very beat.
    always_comb begin
        sop_beat = bus.in_valid && bus.in_sop;
        len_eff  = sop_beat ? LEN_W'(clamp_len(int'(bus.line_len), LINE_WIDTH)) : len_q;
        wr_ptr   = sop_beat ? '0 : ptr_q;
        rows_eff = sop_beat ? '0 : rows_q;
        last_col = (LEN_W'(wr_ptr) == (len_eff - LEN_W'(1)));
    end

    always_comb begin
        ptr_d          = ptr_q;
        rows_d         = rows_q;
        len_d          = len_q;
        taps_d         = taps_q;
        col_d          = col_q;
        out_valid_d    = bus.in_valid;
        window_valid_d = 1'b0;
        if (bus.in_valid) begin
            ptr_d          = last_col ? '0 : (wr_ptr + PTR_W'(1));
            rows_d         = (last_col && (rows_eff != RF_W'(N_ROWS))) ? (rows_eff + RF_W'(1)) : rows_eff;
            len_d          = len_eff;
            col_d          = wr_ptr;
            window_valid_d = (rows_eff == RF_W'(N_ROWS));
            for (int k = 0; k <= N_ROWS; k++) begin
`ifdef LINE_BUF_ZERO_PAD_EN
                taps_d[tap_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = (k > int'(rows_eff)) ? '0 : col_rd[k];
`else
                taps_d[tap_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = col_rd[k];
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q          <= '0;
            rows_q         <= '0;
            len_q          <= LEN_W'(LINE_WIDTH);
            taps_q         <= '0;
            col_q          <= '0;
            out_valid_q    <= 1'b0;
            window_valid_q <= 1'b0;
        end else begin
            ptr_q          <= ptr_d;
            rows_q         <= rows_d;
            len_q          <= len_d;
            taps_q         <= taps_d;
            col_q          <= col_d;
            out_valid_q    <= out_valid_d;
            window_valid_q <= window_valid_d;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.window_valid = window_valid_q;
    assign bus.taps         = taps_q;
    assign bus.col_idx      = col_q;
endmodule

// File: tb/tb_line_buffer_taps.sv
// Directed bench for line_buffer_taps (LINE_WIDTH=640, DATA_WIDTH=26, N_ROWS=2).
module tb_line_buffer_taps;
    localparam int LW  = 640;
    localparam int DW  = 26;
    localparam int NR  = 2;
    localparam int LNW = $clog2(LW + 1);

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    line_buffer_taps_if #(.LINE_WIDTH(LW), .DATA_WIDTH(DW), .N_ROWS(NR)) bus ();

    line_buffer_taps #(.LINE_WIDTH(LW), .DATA_WIDTH(DW), .N_ROWS(NR)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [3*DW-1:0] tp(input int t2, input int t1, input int t0);
        logic [DW-1:0] a, b, c;
        a = DW'(t2);
        b = DW'(t1);
        c = DW'(t0);
        return {a, b, c};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic s, input int d, input int len);
        bus.in_valid = v;
        bus.in_sop   = s;
        bus.data_in  = DW'(d);
        bus.line_len = LNW'(len);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3*DW-1:0] exp_taps;
        int t1, t2, ln, c;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.data_in  = '0;
        bus.line_len = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_window_valid", bus.window_valid, 0);
        chk("rst_taps", bus.taps, 0);
        chk("rst_col_idx", bus.col_idx, 0);
        rst = 1'b0;

        // Frame A: line_len=4, pixels 0..11, sop on the first.
        for (int i = 0; i < 12; i++) begin
            step(1'b1, i == 0, i, 4);
            chk("a_out_valid", bus.out_valid, 1);
            chk("a_col_idx", bus.col_idx, i % 4);
            chk("a_window_valid", bus.window_valid, (i >= 8));
            chk("a_tap0", bus.taps[DW-1:0], i);
            if (i >= 4) chk("a_tap1", bus.taps[DW +: DW], i - 4);
            if (i >= 8) chk("a_taps", bus.taps, tp(i - 8, i - 4, i));
        end
        step(1'b0, 1'b0, 999, 4);
        chk("idle_out_valid", bus.out_valid, 0);
        chk("idle_window_valid", bus.window_valid, 0);
        chk("idle_taps_hold", bus.taps, tp(3, 7, 11));
        chk("idle_col_hold", bus.col_idx, 3);

        // Frame B: same stream, one idle cycle after every beat.
        for (int i = 0; i < 12; i++) begin
            ln = i / 4;
            c  = i % 4;
`ifdef LINE_BUF_ZERO_PAD_EN
            t1 = (ln == 0) ? 0 : ((ln == 1) ? c : 4 + c);
            t2 = (ln == 2) ? c : 0;
`else
            t1 = (ln == 0) ? 8 + c : ((ln == 1) ? c : 4 + c);
            t2 = (ln == 0) ? 4 + c : ((ln == 1) ? 8 + c : c);
`endif
            exp_taps = tp(t2, t1, i);
            step(1'b1, i == 0, i, 4);
            chk("b_out_valid", bus.out_valid, 1);
            chk("b_col_idx", bus.col_idx, c);
            chk("b_window_valid", bus.window_valid, (i >= 8));
            chk("b_taps", bus.taps, exp_taps);
            step(1'b0, 1'b1, 555, 1);
            chk("b_gap_out_valid", bus.out_valid, 0);
            chk("b_gap_window_valid", bus.window_valid, 0);
            chk("b_gap_taps_hold", bus.taps, exp_taps);
        end

        // Frame C: line_len=0 clamps to 640; later line_len changes without sop are ignored.
        for (int i = 0; i <= LW; i++) begin
            step(1'b1, i == 0, i, (i == 0) ? 0 : 4);
            if (i == 3 || i == 4 || i == LW - 1)
                chk("c_col_idx", bus.col_idx, i);
            if (i == LW) begin
                chk("c_wrap_col_idx", bus.col_idx, 0);
                chk("c_wrap_window_valid", bus.window_valid, 0);
            end
        end

        // Frame D: sop mid-line restarts fill counting.
        for (int i = 0; i < 14; i++) begin
            step(1'b1, i == 0, 20 + i, 4);
            if (i >= 12) chk("d_pre_window_valid", bus.window_valid, 1);
        end
        for (int j = 0; j <= 8; j++) begin
            step(1'b1, j == 0, 50 + j, 4);
            chk("d_col_idx", bus.col_idx, j % 4);
            chk("d_window_valid", bus.window_valid, (j == 8));
        end
        chk("d_taps", bus.taps, tp(50, 54, 58));

        // Asynchronous reset between clock edges.
        step(1'b1, 1'b0, 77, 4);
        step(1'b1, 1'b0, 78, 4);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_window_valid", bus.window_valid, 0);
        chk("arst_taps", bus.taps, 0);
        chk("arst_col_idx", bus.col_idx, 0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 200 + i, 4);
            chk("post_rst_col_idx", bus.col_idx, i);
            chk("post_rst_window_valid", bus.window_valid, 0);
        end
        step(1'b0, 1'b0, 0, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
